// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared constants and helpers for the LED PWM output bank.
//   LED_DUTY_W  default width of one duty code
//   LED_PERIOD  default clk1k ticks per PWM period
//   DUTY_OFF    code meaning "always off"
//   DUTY_FULL   code meaning "always on" (equals the period)
//   duty_sat()  clamps an incoming code to the full-on value
package led_pwm_pkg;
  localparam int LED_DUTY_W = 4;
  localparam int LED_PERIOD = 10;
  localparam int DUTY_OFF   = 0;
  localparam int DUTY_FULL  = LED_PERIOD;

  function automatic int duty_sat(input int code, input int full = DUTY_FULL);
    return (code > full) ? full : code;
  endfunction
endpackage

// File: rtl/led_pwm_chan.sv
// led_pwm_chan: one LED group. Holds the shadow (captured) and active (in use)
// duty codes and drives the registered PWM output.
//   Build option: LED_RAMP_EN -- active steps one code per boundary toward
//   the target instead of jumping.
// Ports:
//   clk1k, RESET   PWM tick clock, async active-low reset
//   enable         PWM running
//   cnt            shared phase counter (value before increment)
//   boundary       this edge is a period boundary (or PWM disabled)
//   load, duty_in  capture strobe and raw code for this group
//   done           active will equal the target after this edge
//   led_out        registered PWM drive
module led_pwm_chan
  import led_pwm_pkg::*;
#(
  parameter int PERIOD = LED_PERIOD,
  parameter int DUTY_W = LED_DUTY_W
) (
  input  logic              clk1k,
  input  logic              RESET,
  input  logic              enable,
  input  logic [DUTY_W-1:0] cnt,
  input  logic              boundary,
  input  logic              load,
  input  logic [DUTY_W-1:0] duty_in,
  output logic              done,
  output logic              led_out
);
  logic [DUTY_W-1:0] shadow_q, shadow_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic [DUTY_W-1:0] code_sat, target;
  logic              led_q, led_d;

  always_comb begin
    code_sat = DUTY_W'(duty_sat(int'(duty_in), PERIOD));
    shadow_d = load ? code_sat : shadow_q;
    // A load on a boundary edge bypasses the shadow as the target.
    target   = load ? code_sat : shadow_q;
    active_d = active_q;
    if (boundary) begin
`ifdef LED_RAMP_EN
      if (active_q < target)      active_d = active_q + 1'b1;
      else if (active_q > target) active_d = active_q - 1'b1;
`else
      active_d = target;
`endif
    end
    done  = (active_d == target);
    led_d = enable && (cnt < active_q);
  end

  always_ff @(posedge clk1k or negedge RESET) begin
    if (!RESET) begin
      shadow_q <= DUTY_W'(DUTY_OFF);
      active_q <= DUTY_W'(DUTY_OFF);
      led_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      led_q    <= led_d;
    end
  end

  assign led_out = led_q;
endmodule

// File: rtl/led_pwm_bank.sv
// led_pwm_bank: turns per-group duty codes into low-frequency PWM on clk1k.
// Duty loads are double-buffered and take effect only on period boundaries.
//   Build option: LED_RAMP_EN -- codes ramp one step per boundary.
// Ports:
//   clk1k, RESET   1 kHz tick clock, async active-low reset
//   enable         1 = PWM running, 0 = outputs off and counter parked
//   duty_in        packed codes, group g at [g*DUTY_W +: DUTY_W]
//   duty_load      one-cycle capture strobe
//   load_ack       pulse when loaded codes become active
//   period_start   pulse aligned with the first led_out cycle of a period
//   led_out        registered PWM drive per group
module led_pwm_bank
  import led_pwm_pkg::*;
#(
  parameter int NGRP   = 4,
  parameter int PERIOD = LED_PERIOD,
  parameter int DUTY_W = LED_DUTY_W
) (
  input  logic                   clk1k,
  input  logic                   RESET,
  input  logic                   enable,
  input  logic [NGRP*DUTY_W-1:0] duty_in,
  input  logic                   duty_load,
  output logic                   load_ack,
  output logic                   period_start,
  output logic [NGRP-1:0]        led_out
);
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic              load_ack_q, load_ack_d;
  logic              period_start_q, period_start_d;
  logic              boundary, all_done;
  logic [NGRP-1:0]   done;

  // While disabled every edge counts as a boundary so loads land at once.
  assign boundary = !enable || (cnt_q == DUTY_W'(PERIOD-1));
  assign all_done = &done;

  always_comb begin
    cnt_d = '0;
    if (enable) cnt_d = (cnt_q == DUTY_W'(PERIOD-1)) ? '0 : cnt_q + 1'b1;

    pending_d = pending_q;
    if (duty_load) pending_d = 1'b1;
    // Without ramping all_done is always true on a boundary.
    if (boundary)  pending_d = (pending_q || duty_load) && !all_done;

    load_ack_d     = boundary && (pending_q || duty_load) && all_done;
    // Same timing as led_out: registered from the cnt==0 edge.
    period_start_d = enable && (cnt_q == '0);
  end

  always_ff @(posedge clk1k or negedge RESET) begin
    if (!RESET) begin
      cnt_q          <= '0;
      pending_q      <= 1'b0;
      load_ack_q     <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      load_ack_q     <= load_ack_d;
      period_start_q <= period_start_d;
    end
  end

  for (genvar g = 0; g < NGRP; g++) begin : g_chan
    led_pwm_chan #(.PERIOD(PERIOD), .DUTY_W(DUTY_W)) u_chan (
      .clk1k   (clk1k),
      .RESET   (RESET),
      .enable  (enable),
      .cnt     (cnt_q),
      .boundary(boundary),
      .load    (duty_load),
      .duty_in (duty_in[g*DUTY_W +: DUTY_W]),
      .done    (done[g]),
      .led_out (led_out[g])
    );
  end

  assign load_ack     = load_ack_q;
  assign period_start = period_start_q;
endmodule

// File: tb/tb_led_pwm_bank.sv
// tb_led_pwm_bank: directed tests for led_pwm_bank (NGRP=4, PERIOD=10).
module tb_led_pwm_bank;
  localparam int NGRP = 4;
  localparam int DW   = 4;
  localparam int PER  = 10;

  logic                 clk1k = 1'b0;
  logic                 RESET;
  logic                 enable;
  logic [NGRP*DW-1:0]   duty_in;
  logic                 duty_load;
  logic                 load_ack;
  logic                 period_start;
  logic [NGRP-1:0]      led_out;

  int checks   = 0;
  int failures = 0;

  led_pwm_bank #(.NGRP(NGRP), .PERIOD(PER), .DUTY_W(DW)) dut (
    .clk1k       (clk1k),
    .RESET       (RESET),
    .enable      (enable),
    .duty_in     (duty_in),
    .duty_load   (duty_load),
    .load_ack    (load_ack),
    .period_start(period_start),
    .led_out     (led_out)
  );

  always #5 clk1k = ~clk1k;

  task automatic tick();
    @(posedge clk1k);
    #1;
  endtask

  // Advance until period_start is seen (may already be high).
  task automatic wait_ps(input string name);
    int n = 0;
    while (period_start !== 1'b1 && n < 3*PER) begin
      tick();
      n++;
    end
    checks++;
    if (period_start !== 1'b1) begin
      failures++;
      $display("FAIL %s_wait_ps: period_start=%b want 1 within %0d cycles", name, period_start, 3*PER);
    end
  endtask

  // Current observation is cycle 0 of a period; records 10 cycles.
  task automatic measure_period(input int exp [NGRP], input string name);
    logic [PER-1:0] pat [NGRP];
    logic [PER:0]   ones;
    int             ps_err = 0;
    for (int k = 0; k < PER; k++) begin
      if (k > 0) tick();
      for (int g = 0; g < NGRP; g++) pat[g][k] = led_out[g];
      if (period_start !== (k == 0)) ps_err++;
    end
    for (int g = 0; g < NGRP; g++) begin
      ones = (11'd1 << exp[g]) - 11'd1;
      checks++;
      if (pat[g] !== ones[PER-1:0]) begin
        failures++;
        $display("FAIL %s_g%0d: pattern=%b want %b", name, g, pat[g], ones[PER-1:0]);
      end
    end
    checks++;
    if (ps_err != 0) begin
      failures++;
      $display("FAIL %s_period_start: %0d bad cycles want 0", name, ps_err);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; enable = 1'b0; duty_in = '0; duty_load = 1'b0;
    #2;
    checks++;
    if ({led_out, load_ack, period_start} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 000000", {led_out, load_ack, period_start});
    end
    tick(); tick();
    RESET = 1'b1;
    tick();
    checks++;
    if ({led_out, load_ack, period_start} !== 6'b0) begin
      failures++;
      $display("FAIL reset_release: got %b want 000000", {led_out, load_ack, period_start});
    end
  endtask

  task automatic test_idle();
    int ps_cnt = 0, led_err = 0, first = -1, second = -1;
    enable = 1'b1;
    for (int t = 0; t < 3*PER; t++) begin
      tick();
      if (period_start === 1'b1) begin
        if (ps_cnt == 0) first = t;
        if (ps_cnt == 1) second = t;
        ps_cnt++;
      end
      if (led_out !== '0) led_err++;
    end
    checks++;
    if (ps_cnt != 3) begin
      failures++;
      $display("FAIL idle_ps_count: got %0d want 3", ps_cnt);
    end
    checks++;
    if (first != 0 || second != PER) begin
      failures++;
      $display("FAIL idle_ps_pos: got %0d,%0d want 0,%0d", first, second, PER);
    end
    checks++;
    if (led_err != 0) begin
      failures++;
      $display("FAIL idle_led: %0d high cycles want 0", led_err);
    end
  endtask

  task automatic test_load();
    int err = 0;
    wait_ps("load");
    duty_in = {4'd10, 4'd0, 4'd5, 4'd3};
    duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
    if (load_ack !== 1'b0 || led_out !== '0) err++;
    for (int k = 2; k < PER; k++) begin
      tick();
      if (load_ack !== (k == PER-1)) err++;
      if (led_out !== '0) err++;
    end
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL load_ack_timing: %0d bad cycles want 0", err);
    end
    tick();
    checks++;
    if (period_start !== 1'b1 || load_ack !== 1'b0) begin
      failures++;
      $display("FAIL load_new_period: ps=%b ack=%b want ps=1 ack=0", period_start, load_ack);
    end
    measure_period('{3, 5, 0, 10}, "load");
  endtask

  task automatic test_saturate();
    wait_ps("sat_a");
    duty_in = {4'd10, 4'd0, 4'd5, 4'd15};
    duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
    wait_ps("sat_b");
    measure_period('{10, 5, 0, 10}, "sat1");
    tick();
    measure_period('{10, 5, 0, 10}, "sat2");
  endtask

  task automatic test_bypass();
    wait_ps("byp");
    for (int k = 1; k < PER-1; k++) tick();
    duty_in = {4'd10, 4'd0, 4'd5, 4'd7};
    duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
    checks++;
    if (load_ack !== 1'b1) begin
      failures++;
      $display("FAIL bypass_ack: got %b want 1", load_ack);
    end
    tick();
    checks++;
    if (period_start !== 1'b1 || load_ack !== 1'b0) begin
      failures++;
      $display("FAIL bypass_period: ps=%b ack=%b want ps=1 ack=0", period_start, load_ack);
    end
    measure_period('{7, 5, 0, 10}, "bypass");
    checks++;
    if (load_ack !== 1'b0) begin
      failures++;
      $display("FAIL bypass_no_second_ack: got %b want 0", load_ack);
    end
  endtask

  task automatic test_enable();
    int err = 0;
    wait_ps("en");
    tick(); tick();
    checks++;
    if (led_out !== 4'b1010 + 4'b0001) begin
      failures++;
      $display("FAIL en_mid_pulse: led=%b want 1011", led_out);
    end
    enable = 1'b0;
    duty_in = {4'd10, 4'd0, 4'd5, 4'd2};
    duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
    checks++;
    if (led_out !== '0 || load_ack !== 1'b1 || period_start !== 1'b0) begin
      failures++;
      $display("FAIL en_off: led=%b ack=%b ps=%b want 0000 1 0", led_out, load_ack, period_start);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (led_out !== '0 || load_ack !== 1'b0 || period_start !== 1'b0) err++;
    end
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL en_parked: %0d bad cycles want 0", err);
    end
    enable = 1'b1;
    tick();
    measure_period('{2, 5, 0, 10}, "reenable");
  endtask

  task automatic test_reset_mid();
    int err = 0;
    wait_ps("rst");
    duty_in = {4'd1, 4'd1, 4'd1, 4'd1};
    duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
    tick();
    RESET = 1'b0;
    #1;
    checks++;
    if ({led_out, load_ack, period_start} !== 6'b0) begin
      failures++;
      $display("FAIL rst_mid: got %b want 000000", {led_out, load_ack, period_start});
    end
    #2;
    RESET = 1'b1;
    for (int k = 0; k < 2*PER; k++) begin
      tick();
      if (load_ack !== 1'b0 || led_out !== '0) err++;
    end
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL rst_lost_load: %0d bad cycles want 0", err);
    end
  endtask

`ifdef LED_RAMP_EN
  task automatic test_ramp();
    enable = 1'b0;
    duty_in = {4'd2, 4'd2, 4'd2, 4'd2};
    duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    enable = 1'b1;
    tick();
    wait_ps("ramp");
    duty_in = {4'd6, 4'd6, 4'd6, 4'd6};
    duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
    for (int s = 3; s <= 6; s++) begin
      wait_ps("ramp_step");
      measure_period('{s, s, s, s}, "ramp");
      checks++;
      if (load_ack !== (s == 5)) begin
        failures++;
        $display("FAIL ramp_ack_s%0d: got %b want %b", s, load_ack, (s == 5));
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
`ifdef LED_RAMP_EN
    test_ramp();
`else
    test_load();
    test_saturate();
    test_bypass();
    test_enable();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
